pe_issue_pipe: RTL
==================

Name: pe_issue_pipe

Overview:
- Instruction issue and multiply pipeline placed directly upstream of the per-lane arithmetic units of the processing element.
- Accepts one instruction per cycle over a valid/ready handshake, together with packed vector and matrix operands.
- Computes the per-lane signed products in a fixed-latency pipeline.
- Delivers one-hot operation strobes, shift value, vector slices and products to the lanes, all time-aligned so every lane sees a coherent operation in a single cycle.

Parameters:
- LANES, 4, number of lanes served.
- INPUT_WIDTH, 8, per-lane operand width (signed).
- ACC_WIDTH, 16, per-lane accumulator/product width.
- VALUE_BITWIDTH, 5, instruction value field width.
- MUL_STAGES, 2, pipeline depth from accept to issue; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  instruction accepted when valid & ready.
- instr_op  in  3  opcode: 0 NOP, 1 MAC, 2 RND, 3 PASS, 4 OUT, 5 CLR, 6/7 illegal.
- instr_value  in  VALUE_BITWIDTH  shift amount for RND; ignored otherwise.
- vector_in  in  LANES*INPUT_WIDTH  packed signed operands; lane i = bits [i*INPUT_WIDTH +: INPUT_WIDTH].
- matrix_in  in  LANES*INPUT_WIDTH  packed signed operands, same packing.
- stall  in  1  downstream hold request; freezes the pipeline.
- do_mac, do_shift, do_pass, do_out, do_clr  out  1 each  one-hot issue strobes.
- shift_value  out  VALUE_BITWIDTH  value aligned with do_shift.
- vector_out  out  LANES*INPUT_WIDTH  vector operands aligned with the strobes.
- mul_result  out  LANES*ACC_WIDTH  per-lane products aligned with the strobes.
- busy  out  1  any valid entry in the pipeline.
- illegal_op  out  1  sticky flag: an illegal opcode was accepted.
- issue_count  out  16  count of non-NOP operations issued; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valid bits, strobes, shift_value, vector_out, mul_result, illegal_op and issue_count are 0. busy is 0. instr_ready is 0 while rst_n is low.
- Reset asserted mid-operation discards all in-flight instructions; nothing is issued for them after reset releases.
- Handshake:
  - instr_ready = !stall (combinational); it is independent of instr_valid.
  - Acceptance occurs on a cycle where instr_valid & instr_ready are both high.
  - instr_op, instr_value, vector_in and matrix_in are sampled at acceptance only.
- Pipeline:
  - Shift register of MUL_STAGES entries, each holding {valid, op, value, vector, product}.
  - Stage 1 captures the operands and computes the product: signed INPUT_WIDTH x INPUT_WIDTH, full 2*INPUT_WIDTH result.
  - Product width rule: sign-extend to ACC_WIDTH when ACC_WIDTH >= 2*INPUT_WIDTH; otherwise truncate to the low ACC_WIDTH bits (wrap).
  - The remaining stages only delay the entry.
  - Latency: an instruction accepted at edge N issues in the cycle following edge N+MUL_STAGES-1. With MUL_STAGES=2, it is accepted at edge 0, loaded into stage 1 at edge 0, moved to stage 2 at edge 1, and its strobe is high during the cycle after edge 1.
  - Strobes are decoded combinationally from the final stage.
- Stall:
  - While stall=1, no entry advances, nothing is accepted, and every do_* strobe is forced to 0 so the lanes hold.
  - vector_out, mul_result and shift_value keep the final-stage contents during stall.
  - When stall deasserts, the final-stage entry issues exactly once: no duplicate issue and no loss.
- Bubbles: a cycle with no acceptance inserts a valid=0 entry. Such an entry produces no strobe.
- Decode:
  - Exactly one strobe is high for ops 1-5 when the final stage is valid and stall=0.
  - NOP and illegal ops produce no strobe.
  - shift_value = final-stage value when do_shift is high, else 0.
- illegal_op: set at acceptance of op 6 or 7; cleared only by reset.
- issue_count: increments on every cycle any strobe is high; holds at 16'hFFFF.
- busy: OR of all stage valid bits.
- Ordering: instructions issue strictly in acceptance order. No reordering or hazard interlock is needed, since all ops traverse the same pipeline.

Test Plan:
- Basic latency: MUL_STAGES=2. Accept MAC with lane0 vector=3, matrix=-4 -> do_mac high exactly 2 cycles after acceptance, lane0 mul_result=16'hFFF4, busy high for those 2 cycles.
- Extremes and width: vector=-128, matrix=-128 -> mul_result=16'h4000. With ACC_WIDTH=12, the same operands give 12'h000 (wrap). vector=127, matrix=-128 -> 16'hC080.
- Back-to-back stream: CLR, PASS(vector=5), MAC, RND(value=3), OUT on consecutive cycles -> strobes in the same order on 5 consecutive cycles. shift_value=3 only with do_shift. issue_count=5.
- Stall mid-stream: assert stall for 3 cycles while MAC is in the final stage -> all strobes 0 and instr_ready 0 during stall. do_mac pulses exactly once after release, with mul_result unchanged.
- Illegal op and NOP: accept op 7 then op 0 -> no strobes, illegal_op=1 and sticky, issue_count unchanged.
- Async reset: drop rst_n with 2 instructions in flight -> all outputs 0 immediately. After release, no strobes for the discarded instructions and busy=0.

Source files
------------

// File: rtl/pe_issue_pipe_if.sv
// Instruction handshake bundle between the sequencer and the PE issue pipeline.
interface pe_issue_pipe_if #(
  parameter int unsigned LANES          = 4,
  parameter int unsigned INPUT_WIDTH    = 8,
  parameter int unsigned VALUE_BITWIDTH = 5
);
  localparam int unsigned VEC_W = LANES * INPUT_WIDTH;

  logic                      instr_valid;
  logic                      instr_ready;
  logic [2:0]                instr_op;
  logic [VALUE_BITWIDTH-1:0] instr_value;
  logic [VEC_W-1:0]          vector_in;
  logic [VEC_W-1:0]          matrix_in;

  modport master (
    output instr_valid, instr_op, instr_value, vector_in, matrix_in,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_value, vector_in, matrix_in,
    output instr_ready
  );
endinterface

// File: rtl/pe_issue_pipe.sv
// Issue and multiply pipeline feeding the per-lane arithmetic units.
// Operands are multiplied at acceptance and delayed so that strobes, shift
// value, vector slices and products reach the lanes in the same cycle.
module pe_issue_pipe #(
  parameter int unsigned LANES          = 4,
  parameter int unsigned INPUT_WIDTH    = 8,
  parameter int unsigned ACC_WIDTH      = 16,
  parameter int unsigned VALUE_BITWIDTH = 5,
  parameter int unsigned MUL_STAGES     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pe_issue_pipe_if.slave                instr,
  input  logic                          stall,
  output logic                          do_mac,
  output logic                          do_shift,
  output logic                          do_pass,
  output logic                          do_out,
  output logic                          do_clr,
  output logic [VALUE_BITWIDTH-1:0]     shift_value,
  output logic [LANES*INPUT_WIDTH-1:0]  vector_out,
  output logic [LANES*ACC_WIDTH-1:0]    mul_result,
  output logic                          busy,
  output logic                          illegal_op,
  output logic [15:0]                   issue_count
);

  localparam int unsigned VEC_W  = LANES * INPUT_WIDTH;
  localparam int unsigned RES_W  = LANES * ACC_WIDTH;
  localparam int unsigned PROD_W = 2 * INPUT_WIDTH;
  localparam int unsigned LAST   = MUL_STAGES - 1;

  localparam logic [2:0] OP_MAC  = 3'd1;
  localparam logic [2:0] OP_RND  = 3'd2;
  localparam logic [2:0] OP_PASS = 3'd3;
  localparam logic [2:0] OP_OUT  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;

  typedef struct packed {
    logic                      valid;
    logic [2:0]                op;
    logic [VALUE_BITWIDTH-1:0] value;
    logic [VEC_W-1:0]          vector;
    logic [RES_W-1:0]          product;
  } entry_t;

  entry_t                     pipe [MUL_STAGES];
  entry_t                     new_entry;
  logic                       accept;
  logic                       issue;
  logic signed [PROD_W-1:0]   lane_prod [LANES];
  logic [RES_W-1:0]           prod_packed;

  // Ready follows stall only; held low while reset is asserted.
  assign instr.instr_ready = rst_n & ~stall;
  assign accept            = instr.instr_valid & rst_n & ~stall;

  // Full-width signed product per lane.
  always_comb begin
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = '0;
    b = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      a = PROD_W'($signed(instr.vector_in[l*INPUT_WIDTH +: INPUT_WIDTH]));
      b = PROD_W'($signed(instr.matrix_in[l*INPUT_WIDTH +: INPUT_WIDTH]));
      lane_prod[l] = a * b;
    end
  end

  // Fit each product to the accumulator width: sign-extend or wrap.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (ACC_WIDTH >= PROD_W) begin : g_ext
      assign prod_packed[l*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(lane_prod[l]);
    end else begin : g_wrap
      assign prod_packed[l*ACC_WIDTH +: ACC_WIDTH] = lane_prod[l][ACC_WIDTH-1:0];
    end
  end

  // Stage-1 contents for an accepted instruction.
  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.op      = instr.instr_op;
    new_entry.value   = instr.instr_value;
    new_entry.vector  = instr.vector_in;
    new_entry.product = prod_packed;
  end

  // Pipeline shift register; frozen while stalled, bubbles are all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
    end else if (!stall) begin
      pipe[0] <= accept ? new_entry : '0;
      for (int unsigned i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  // One-hot strobe decode from the final stage; suppressed during stall.
  always_comb begin
    do_mac      = 1'b0;
    do_shift    = 1'b0;
    do_pass     = 1'b0;
    do_out      = 1'b0;
    do_clr      = 1'b0;
    shift_value = '0;
    issue       = pipe[LAST].valid & ~stall;
    if (issue) begin
      case (pipe[LAST].op)
        OP_MAC:  do_mac   = 1'b1;
        OP_RND:  do_shift = 1'b1;
        OP_PASS: do_pass  = 1'b1;
        OP_OUT:  do_out   = 1'b1;
        OP_CLR:  do_clr   = 1'b1;
        default: ;
      endcase
    end
    // Shift value tracks the final-stage RND entry so it also holds through stall.
    if (pipe[LAST].valid && pipe[LAST].op == OP_RND) shift_value = pipe[LAST].value;
  end

  assign vector_out = pipe[LAST].vector;
  assign mul_result = pipe[LAST].product;

  // Busy whenever any stage holds a valid entry.
  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < MUL_STAGES; i++) busy = busy | pipe[i].valid;
  end

  // Sticky illegal-opcode flag and saturating issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op  <= 1'b0;
      issue_count <= '0;
    end else begin
      if (accept && instr.instr_op[2] && instr.instr_op[1]) illegal_op <= 1'b1;
      if ((do_mac | do_shift | do_pass | do_out | do_clr) && issue_count != 16'hFFFF)
        issue_count <= issue_count + 16'd1;
    end
  end

endmodule
